q_episode_controller: RTL and testbench

- Top-level sequencer for the Q-learning agent datapath. Runs training as a series of episodes of steps.
- Each step runs four phases in order: request a transition from the environment, capture next_state/reward, pulse the Q-update accelerator enable, then wait out its fixed latency.
- Drives the agent's en, state, next_state, reward, gamma and alpha inputs.
- Tracks step and episode counts, terminal-state detection and run completion.

---
 rtl/q_episode_controller.sv | 155 +++++++++++++++
 tb/tb_q_episode_controller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_episode_controller.sv
// Episode/step sequencer for the Q-learning agent: fetches a transition from the
// environment, fires the Q-update accelerator, waits out its latency, then advances.
module q_episode_controller #(
    parameter int STATE_W      = 6,
    parameter int REWARD_W     = 16,
    parameter int START_STATE  = 0,
    parameter int GOAL_STATE   = 63,
    parameter int MAX_STEPS    = 64,
    parameter int NUM_EPISODES = 100,
    parameter int ACC_LAT      = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [3:0]          cfg_gamma,
    input  logic [3:0]          cfg_alpha,
    output logic                env_req,
    input  logic                env_valid,
    input  logic [STATE_W-1:0]  env_next_state,
    input  logic [REWARD_W-1:0] env_reward,
    output logic [STATE_W-1:0]  cur_state,
    output logic                acc_en,
    output logic [STATE_W-1:0]  acc_state,
    output logic [STATE_W-1:0]  acc_next_state,
    output logic [REWARD_W-1:0] acc_reward,
    output logic [3:0]          acc_gamma,
    output logic [3:0]          acc_alpha,
    output logic [15:0]         step_cnt,
    output logic [15:0]         episode_cnt,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_ENV, S_UPDATE, S_WAIT_ACC, S_ADVANCE, S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [STATE_W-1:0]  cur_state_reg;
    logic [STATE_W-1:0]  acc_state_reg;
    logic [STATE_W-1:0]  acc_next_state_reg;
    logic [REWARD_W-1:0] acc_reward_reg;
    logic [3:0]          gamma_reg;
    logic [3:0]          alpha_reg;
    logic [15:0]         step_cnt_reg;
    logic [15:0]         episode_cnt_reg;
    logic [15:0]         wait_cnt_reg;

    logic [15:0] step_inc;
    logic [15:0] episode_inc;
    logic        terminal;
    logic        last_episode;

    assign step_inc     = step_cnt_reg + 16'd1;
    assign episode_inc  = episode_cnt_reg + 16'd1;
    assign terminal     = (acc_next_state_reg == STATE_W'(GOAL_STATE)) ||
                          (step_inc == 16'(MAX_STEPS));
    assign last_episode = (episode_inc == 16'(NUM_EPISODES));

    always_comb begin
        state_next = state_reg;
        env_req    = 1'b0;
        acc_en     = 1'b0;
        case (state_reg)
            S_IDLE:     if (start) state_next = S_REQ;
            S_REQ: begin
                env_req    = 1'b1;
                state_next = S_WAIT_ENV;
            end
            S_WAIT_ENV: if (env_valid) state_next = S_UPDATE;
            S_UPDATE: begin
                acc_en     = 1'b1;
                state_next = S_WAIT_ACC;
            end
            S_WAIT_ACC: if (wait_cnt_reg == 16'd0) state_next = S_ADVANCE;
            S_ADVANCE:  state_next = (terminal && last_episode) ? S_DONE : S_REQ;
            S_DONE:     if (start) state_next = S_REQ;
            default:    state_next = S_IDLE;
        endcase
        // Abort overrides everything, including a simultaneous start.
        if (abort) begin
            state_next = S_IDLE;
            env_req    = 1'b0;
            acc_en     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg          <= S_IDLE;
            cur_state_reg      <= STATE_W'(START_STATE);
            acc_state_reg      <= '0;
            acc_next_state_reg <= '0;
            acc_reward_reg     <= '0;
            gamma_reg          <= '0;
            alpha_reg          <= '0;
            step_cnt_reg       <= '0;
            episode_cnt_reg    <= '0;
            wait_cnt_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (!abort) begin
                case (state_reg)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            cur_state_reg   <= STATE_W'(START_STATE);
                            step_cnt_reg    <= '0;
                            episode_cnt_reg <= '0;
                            gamma_reg       <= cfg_gamma;
                            alpha_reg       <= cfg_alpha;
                        end
                    end
                    S_WAIT_ENV: begin
                        if (env_valid) begin
                            acc_state_reg      <= cur_state_reg;
                            acc_next_state_reg <= env_next_state;
                            acc_reward_reg     <= env_reward;
                        end
                    end
                    S_UPDATE:   wait_cnt_reg <= 16'(ACC_LAT - 1);
                    S_WAIT_ACC: if (wait_cnt_reg != 16'd0) wait_cnt_reg <= wait_cnt_reg - 16'd1;
                    S_ADVANCE: begin
                        if (!terminal) begin
                            cur_state_reg <= acc_next_state_reg;
                            step_cnt_reg  <= step_inc;
                        end else if (!last_episode) begin
                            episode_cnt_reg <= episode_inc;
                            step_cnt_reg    <= '0;
                            cur_state_reg   <= STATE_W'(START_STATE);
                        end else begin
                            // Final step: keep its count visible and leave cur_state as is.
                            episode_cnt_reg <= episode_inc;
                            step_cnt_reg    <= step_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cur_state      = cur_state_reg;
    assign acc_state      = acc_state_reg;
    assign acc_next_state = acc_next_state_reg;
    assign acc_reward     = acc_reward_reg;
    assign acc_gamma      = gamma_reg;
    assign acc_alpha      = alpha_reg;
    assign step_cnt       = step_cnt_reg;
    assign episode_cnt    = episode_cnt_reg;
    assign busy           = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign done           = (state_reg == S_DONE);

endmodule

// File: tb/tb_q_episode_controller.sv
// Scoreboard bench for q_episode_controller: directed environment responses,
// expected env_req / acc_en transactions queued and checked by a monitor.
module tb_q_episode_controller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [3:0]  cfg_gamma;
    logic [3:0]  cfg_alpha;
    logic        env_req;
    logic        env_valid;
    logic [5:0]  env_next_state;
    logic [15:0] env_reward;
    logic [5:0]  cur_state;
    logic        acc_en;
    logic [5:0]  acc_state;
    logic [5:0]  acc_next_state;
    logic [15:0] acc_reward;
    logic [3:0]  acc_gamma;
    logic [3:0]  acc_alpha;
    logic [15:0] step_cnt;
    logic [15:0] episode_cnt;
    logic        busy;
    logic        done;

    q_episode_controller #(
        .STATE_W(6), .REWARD_W(16), .START_STATE(0), .GOAL_STATE(63),
        .MAX_STEPS(6), .NUM_EPISODES(3), .ACC_LAT(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_gamma(cfg_gamma), .cfg_alpha(cfg_alpha),
        .env_req(env_req), .env_valid(env_valid),
        .env_next_state(env_next_state), .env_reward(env_reward),
        .cur_state(cur_state), .acc_en(acc_en), .acc_state(acc_state),
        .acc_next_state(acc_next_state), .acc_reward(acc_reward),
        .acc_gamma(acc_gamma), .acc_alpha(acc_alpha),
        .step_cnt(step_cnt), .episode_cnt(episode_cnt),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic [5:0]  cur;
        logic [15:0] stp;
        logic [15:0] ep;
        int          gap;
    } req_exp_t;

    typedef struct {
        logic [5:0]  st;
        logic [5:0]  nx;
        logic [15:0] rw;
        logic [3:0]  g;
        logic [3:0]  a;
        logic [15:0] stp;
        logic [15:0] ep;
        int          lat;
    } acc_exp_t;

    req_exp_t req_q[$];
    acc_exp_t acc_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_req_cyc = 0;
    int req_seen = 0;
    int acc_seen = 0;

    // Run 1 table: MAX_STEPS=6, NUM_EPISODES=3, goal=63.
    // Ep0 hits goal on step 5, ep1 runs out at 6 steps, ep2 hits goal at once -> DONE.
    int t_nxt [12] = '{1, 2, 3, 4, 63, 10, 20, 30, 40, 50, 60, 63};
    int t_rew [12] = '{1, 1, 1, 1, 100, 'hFFFB, 2, 3, 4, 5, 6, 7};
    int t_dly [12] = '{0, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0};
    int t_spr [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    int t_cur [12] = '{0, 1, 2, 3, 4, 0, 10, 20, 30, 40, 50, 0};
    int t_stp [12] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 5, 0};
    int t_ep  [12] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 2};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the expected transaction whenever the DUT presents one.
    always @(negedge clk) begin
        if (env_req === 1'b1) begin
            req_seen++;
            if (req_q.size() == 0) begin
                chk("unexpected_env_req", 32'd1, 32'd0);
            end else begin
                req_exp_t e;
                e = req_q.pop_front();
                $display("env_req  cyc=%0d cur_state=%0d step=%0d ep=%0d", cyc, cur_state, step_cnt, episode_cnt);
                chk("req_cur_state", 32'(cur_state), 32'(e.cur));
                chk("req_step_cnt", 32'(step_cnt), 32'(e.stp));
                chk("req_episode_cnt", 32'(episode_cnt), 32'(e.ep));
                if (e.gap > 0) chk("req_period", 32'(cyc - last_req_cyc), 32'(e.gap));
            end
            last_req_cyc = cyc;
        end
        if (acc_en === 1'b1) begin
            acc_seen++;
            if (acc_q.size() == 0) begin
                chk("unexpected_acc_en", 32'd1, 32'd0);
            end else begin
                acc_exp_t a;
                a = acc_q.pop_front();
                $display("acc_en   cyc=%0d st=%0d nx=%0d rw=%0h g=%0d a=%0d", cyc, acc_state, acc_next_state, acc_reward, acc_gamma, acc_alpha);
                chk("acc_state", 32'(acc_state), 32'(a.st));
                chk("acc_next_state", 32'(acc_next_state), 32'(a.nx));
                chk("acc_reward", 32'(acc_reward), 32'(a.rw));
                chk("acc_gamma", 32'(acc_gamma), 32'(a.g));
                chk("acc_alpha", 32'(acc_alpha), 32'(a.a));
                chk("acc_step_cnt", 32'(step_cnt), 32'(a.stp));
                chk("acc_episode_cnt", 32'(episode_cnt), 32'(a.ep));
                chk("acc_latency", 32'(cyc - last_req_cyc), 32'(a.lat));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        bit seen = 0;
        for (int n = 0; n < 100; n++) begin
            if (env_req === 1'b1) begin
                seen = 1;
                break;
            end
            tick();
        end
        if (!seen) chk("env_req_timeout", 32'd0, 32'd1);
    endtask

    task automatic kick(input logic [3:0] g, input logic [3:0] a);
        start = 1'b1;
        cfg_gamma = g;
        cfg_alpha = a;
        tick();
        start = 1'b0;
        cfg_gamma = 4'd0;
        cfg_alpha = 4'd0;
    endtask

    task automatic run_step(input int cur, input int stp, input int ep, input int gap,
                            input int nx, input int rw, input int dly, input int spur,
                            input logic [3:0] g, input logic [3:0] a);
        req_exp_t re;
        acc_exp_t ae;
        re = '{cur: 6'(cur), stp: 16'(stp), ep: 16'(ep), gap: gap};
        req_q.push_back(re);
        wait_req();
        // In REQ: a strobe here must be ignored by the DUT.
        env_valid      = (spur != 0);
        env_next_state = 6'd33;
        env_reward     = 16'hDEAD;
        tick();
        env_valid = 1'b0;
        repeat (dly) tick();
        ae = '{st: 6'(cur), nx: 6'(nx), rw: 16'(rw), g: g, a: a,
               stp: 16'(stp), ep: 16'(ep), lat: 2 + dly};
        acc_q.push_back(ae);
        env_valid      = 1'b1;
        env_next_state = 6'(nx);
        env_reward     = 16'(rw);
        tick();
        env_valid      = 1'b0;
        env_next_state = 6'd0;
        env_reward     = 16'd0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cur_state"}, 32'(cur_state), 32'd0);
        chk({tag, "_step_cnt"}, 32'(step_cnt), 32'd0);
        chk({tag, "_episode_cnt"}, 32'(episode_cnt), 32'd0);
        chk({tag, "_acc_state"}, 32'(acc_state), 32'd0);
        chk({tag, "_acc_next_state"}, 32'(acc_next_state), 32'd0);
        chk({tag, "_acc_reward"}, 32'(acc_reward), 32'd0);
        chk({tag, "_acc_gamma"}, 32'(acc_gamma), 32'd0);
        chk({tag, "_acc_alpha"}, 32'(acc_alpha), 32'd0);
        chk({tag, "_flags"}, {28'd0, busy, done, env_req, acc_en}, 32'd0);
    endtask

    task automatic pulse_env(input int n);
        for (int i = 0; i < n; i++) begin
            env_valid      = ~env_valid;
            env_next_state = 6'(i + 1);
            env_reward     = 16'(i + 1);
            tick();
        end
        env_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_gamma = 4'd0; cfg_alpha = 4'd0;
        env_valid = 1'b0; env_next_state = 6'd0; env_reward = 16'd0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Run 1: three episodes to DONE.
        kick(4'd9, 4'd3);
        for (int i = 0; i < 12; i++) begin
            run_step(t_cur[i], t_stp[i], t_ep[i], (i == 0) ? 0 : 7 + t_dly[i-1],
                     t_nxt[i], t_rew[i], t_dly[i], t_spr[i], 4'd9, 4'd3);
        end
        begin
            bit got = 0;
            for (int n = 0; n < 50; n++) begin
                if (done === 1'b1) begin
                    got = 1;
                    break;
                end
                tick();
            end
            chk("done_reached", 32'(got), 32'd1);
        end
        $display("done     cyc=%0d ep=%0d step=%0d cur=%0d", cyc, episode_cnt, step_cnt, cur_state);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_episode_cnt", 32'(episode_cnt), 32'd3);
        chk("done_step_cnt", 32'(step_cnt), 32'd1);
        chk("done_cur_state", 32'(cur_state), 32'd0);
        chk("done_acc_next_hold", 32'(acc_next_state), 32'd63);
        pulse_env(6);
        repeat (8) tick();
        chk("done_no_acc_en", 32'(acc_seen), 32'd12);
        chk("done_no_env_req", 32'(req_seen), 32'd12);
        chk("done_still_done", 32'(done), 32'd1);

        // Run 2: restart from DONE, abort during WAIT_ACC of the second step.
        kick(4'd6, 4'd10);
        run_step(0, 0, 0, 0, 5, 'h1234, 0, 0, 4'd6, 4'd10);
        run_step(5, 1, 0, 7, 7, 2, 0, 0, 4'd6, 4'd10);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        $display("abort    cyc=%0d busy=%0d step=%0d cur=%0d", cyc, busy, step_cnt, cur_state);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_step_cnt_hold", 32'(step_cnt), 32'd1);
        chk("abort_episode_cnt_hold", 32'(episode_cnt), 32'd0);
        chk("abort_cur_state_hold", 32'(cur_state), 32'd5);
        chk("abort_acc_next_hold", 32'(acc_next_state), 32'd7);
        pulse_env(4);
        repeat (10) tick();
        chk("abort_no_acc_en", 32'(acc_seen), 32'd14);
        chk("abort_no_env_req", 32'(req_seen), 32'd14);
        // abort together with start in IDLE: abort wins.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_beats_start", 32'(busy), 32'd0);

        // Run 3: reset while waiting for the environment.
        kick(4'd4, 4'd2);
        begin
            req_exp_t re;
            re = '{cur: 6'd0, stp: 16'd0, ep: 16'd0, gap: 0};
            req_q.push_back(re);
        end
        wait_req();
        tick();
        rst_n = 1'b0;
        env_valid = 1'b1; env_next_state = 6'd9; env_reward = 16'd55;
        tick();
        rst_n = 1'b1;
        $display("reset    cyc=%0d busy=%0d cur=%0d", cyc, busy, cur_state);
        chk_reset_outputs("midrun_reset");
        tick();
        env_valid = 1'b0;
        repeat (10) tick();
        chk("reset_no_acc_en", 32'(acc_seen), 32'd14);
        chk("reset_no_env_req", 32'(req_seen), 32'd15);
        chk("queues_drained", 32'(req_q.size() + acc_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
